mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter sharing the single memory slave port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read and write). It sits between the IFU/LSU bus masters and the SRAM-model slave and serialises exactly one transaction at a time. Arbitration is round-robin between IFU and LSU; within the LSU, a write wins over a read. All channels use valid/ready handshakes, with the address, data and response phases tracked per transaction.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width
- STRB_W, DATA_W/8, write-strobe width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ifu_arvalid_i / ifu_arready_o  in/out  1  IFU read-address handshake
- ifu_araddr_i  in  ADDR_W  IFU read address
- ifu_rvalid_o / ifu_rready_i  out/in  1  IFU read-data handshake
- ifu_rdata_o  out  DATA_W  IFU read data
- lsu_arvalid_i / lsu_arready_o  in/out  1  LSU read-address handshake
- lsu_araddr_i  in  ADDR_W  LSU read address
- lsu_rvalid_o / lsu_rready_i  out/in  1  LSU read-data handshake
- lsu_rdata_o  out  DATA_W  LSU read data
- lsu_awvalid_i / lsu_awready_o  in/out  1  LSU write-address handshake
- lsu_awaddr_i  in  ADDR_W  LSU write address
- lsu_wvalid_i / lsu_wready_o  in/out  1  LSU write-data handshake
- lsu_wdata_i, lsu_wstrb_i  in  DATA_W, STRB_W  write data, byte strobes
- lsu_bvalid_o / lsu_bready_i  out/in  1  LSU write-response handshake
- mem_arvalid_o / mem_arready_i, mem_araddr_o  out/in  1, ADDR_W  slave read address
- mem_rvalid_i / mem_rready_o, mem_rdata_i  in/out  1, DATA_W  slave read data
- mem_awvalid_o / mem_awready_i, mem_awaddr_o  out/in  1, ADDR_W  slave write address
- mem_wvalid_o / mem_wready_i, mem_wdata_o, mem_wstrb_o  out/in  1, DATA_W, STRB_W  slave write data
- mem_bvalid_i / mem_bready_o  in/out  1  slave write response
- grant_o  out  2  current owner: 00 none, 01 IFU read, 10 LSU read, 11 LSU write

## Operation
- **States and grant:** IDLE, RD_IFU, RD_LSU, WR_LSU. grant_o is the state encoding.
- **Phase flags** (registers, cleared on entry to any grant state):
  - ar_done, set on the AR handshake.
  - aw_done, set on the AW handshake.
  - w_done, set on the W handshake.
- **IDLE arbitration:**
  - Requests: ifu_req = ifu_arvalid_i; lsu_req = lsu_awvalid_i | lsu_arvalid_i.
  - Only one requester: grant it.
  - Both requesting: grant the one not recorded in last_lsu (1 = LSU granted last). last_lsu resets to 0, so the first conflict goes to the LSU.
  - When the LSU is granted: WR_LSU if lsu_awvalid_i, else RD_LSU.
  - last_lsu updates on every grant.
- **RD_x** (x = IFU or LSU):
  - mem_arvalid_o = x_arvalid_i & !ar_done; x_arready_o = mem_arready_i & !ar_done. mem_araddr_o = x_araddr_i.
  - After ar_done: x_rvalid_o = mem_rvalid_i and mem_rready_o = x_rready_i.
  - x_rdata_o = mem_rdata_i while x_rvalid_o is high, else 0.
  - The R handshake returns the FSM to IDLE.
- **WR_LSU:**
  - AW forwarded while !aw_done; W forwarded while !w_done. The two may complete in the same cycle or in either order.
  - Once aw_done & w_done: lsu_bvalid_o = mem_bvalid_i and mem_bready_o = lsu_bready_i.
  - The B handshake returns the FSM to IDLE.
- **Non-granted side:** every valid/ready output toward a non-granted master or unused channel is 0. Address, data and strobe outputs are 0 in IDLE.
- **LSU read while WR_LSU is granted:** lsu_arvalid_i is held off (lsu_arready_o = 0) until a later grant.
- **Reset** (synchronous, any cycle, including mid-transaction):
  - State → IDLE; all flags and last_lsu cleared.
  - All outputs 0 from the cycle after rst is sampled high.
  - An in-flight transaction is abandoned; the slave shares rst.

## Timing
- Request sampled in IDLE at cycle N → grant state and mem_*valid_o asserted at N+1.
- Handshake pass-through is combinational within the grant state; no added latency beyond the single grant cycle.
- Each transaction spends one IDLE cycle after completion. The minimum read with a slave that responds one cycle after AR is 3 cycles: IDLE, AR handshake, R handshake.
- The grant is held until completion regardless of master stalls; no preemption.

## Test plan
- Single IFU read, addr 0x8000_0000, slave returns 0x0000_0000_0041_0113 → grant 01 at N+1, ifu_rvalid_o with that data, grant 00 after the R handshake.
- IFU and LSU reads raised together from reset → LSU served first (grant 10), then IFU (01). Raise both again → LSU then IFU again (last_lsu alternates).
- LSU write 0x8000_1000, wdata 0xDEAD_BEEF, wstrb 0x0F, slave asserts wready two cycles before awready → awvalid/wvalid each drop after their own handshake; lsu_bvalid_o only after both complete.
- LSU asserts awvalid and arvalid simultaneously → WR_LSU (grant 11) first; lsu_arready_o stays 0 until the next grant, which is RD_LSU if the IFU is idle.
- Master back-pressure: ifu_rready_i low for 5 cycles with mem_rvalid_i high → mem_rready_o low and the grant held, completing on the cycle ifu_rready_i rises.
- rst asserted in WR_LSU after aw_done → next cycle: grant 00, all valid/ready outputs 0; a fresh IFU read then completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IFU reads and LSU reads/writes onto one memory
// slave port. Round-robin between IFU and LSU; an LSU write beats an LSU read.
// Exactly one transaction is in flight; each one returns to IDLE for a cycle.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // IFU read channels
  input  logic              ifu_arvalid_i,
  output logic              ifu_arready_o,
  input  logic [ADDR_W-1:0] ifu_araddr_i,
  output logic              ifu_rvalid_o,
  input  logic              ifu_rready_i,
  output logic [DATA_W-1:0] ifu_rdata_o,
  // LSU read channels
  input  logic              lsu_arvalid_i,
  output logic              lsu_arready_o,
  input  logic [ADDR_W-1:0] lsu_araddr_i,
  output logic              lsu_rvalid_o,
  input  logic              lsu_rready_i,
  output logic [DATA_W-1:0] lsu_rdata_o,
  // LSU write channels
  input  logic              lsu_awvalid_i,
  output logic              lsu_awready_o,
  input  logic [ADDR_W-1:0] lsu_awaddr_i,
  input  logic              lsu_wvalid_i,
  output logic              lsu_wready_o,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  input  logic [STRB_W-1:0] lsu_wstrb_i,
  output logic              lsu_bvalid_o,
  input  logic              lsu_bready_i,
  // Memory slave channels
  output logic              mem_arvalid_o,
  input  logic              mem_arready_i,
  output logic [ADDR_W-1:0] mem_araddr_o,
  input  logic              mem_rvalid_i,
  output logic              mem_rready_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_awvalid_o,
  input  logic              mem_awready_i,
  output logic [ADDR_W-1:0] mem_awaddr_o,
  output logic              mem_wvalid_o,
  input  logic              mem_wready_i,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [STRB_W-1:0] mem_wstrb_o,
  input  logic              mem_bvalid_i,
  output logic              mem_bready_o,
  // Current owner of the slave port
  output logic [1:0]        grant_o
);

  // The state encoding doubles as the grant code seen outside.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RD_IFU = 2'b01,
    RD_LSU = 2'b10,
    WR_LSU = 2'b11
  } state_t;

  state_t state, state_nxt;
  logic   ar_done, aw_done, w_done;
  logic   last_lsu;
  logic   ifu_req, lsu_req, lsu_pick;

  assign grant_o = state;

  // State, per-transaction phase flags and round-robin history.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ar_done  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      last_lsu <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        // Every grant is entered from IDLE, so clearing here gives each
        // transaction a fresh set of flags.
        ar_done <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (state_nxt != IDLE) last_lsu <= (state_nxt != RD_IFU);
      end else begin
        if (mem_arvalid_o && mem_arready_i) ar_done <= 1'b1;
        if (mem_awvalid_o && mem_awready_i) aw_done <= 1'b1;
        if (mem_wvalid_o  && mem_wready_i)  w_done  <= 1'b1;
      end
    end
  end

  // Arbitration, next state and the combinational channel routing.
  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    ifu_req       = ifu_arvalid_i;
    lsu_req       = lsu_awvalid_i | lsu_arvalid_i;
    lsu_pick      = lsu_req & (~ifu_req | ~last_lsu);
    ifu_arready_o = 1'b0;
    ifu_rvalid_o  = 1'b0;
    ifu_rdata_o   = '0;
    lsu_arready_o = 1'b0;
    lsu_rvalid_o  = 1'b0;
    lsu_rdata_o   = '0;
    lsu_awready_o = 1'b0;
    lsu_wready_o  = 1'b0;
    lsu_bvalid_o  = 1'b0;
    mem_arvalid_o = 1'b0;
    mem_araddr_o  = '0;
    mem_rready_o  = 1'b0;
    mem_awvalid_o = 1'b0;
    mem_awaddr_o  = '0;
    mem_wvalid_o  = 1'b0;
    mem_wdata_o   = '0;
    mem_wstrb_o   = '0;
    mem_bready_o  = 1'b0;

    unique case (state)
      IDLE: begin
        if (lsu_pick)     state_nxt = lsu_awvalid_i ? WR_LSU : RD_LSU;
        else if (ifu_req) state_nxt = RD_IFU;
      end

      RD_IFU: begin
        mem_araddr_o  = ifu_araddr_i;
        mem_arvalid_o = ifu_arvalid_i & ~ar_done;
        ifu_arready_o = mem_arready_i & ~ar_done;
        if (ar_done) begin
          ifu_rvalid_o = mem_rvalid_i;
          mem_rready_o = ifu_rready_i;
          if (mem_rvalid_i) ifu_rdata_o = mem_rdata_i;
          if (mem_rvalid_i && ifu_rready_i) state_nxt = IDLE;
        end
      end

      RD_LSU: begin
        mem_araddr_o  = lsu_araddr_i;
        mem_arvalid_o = lsu_arvalid_i & ~ar_done;
        lsu_arready_o = mem_arready_i & ~ar_done;
        if (ar_done) begin
          lsu_rvalid_o = mem_rvalid_i;
          mem_rready_o = lsu_rready_i;
          if (mem_rvalid_i) lsu_rdata_o = mem_rdata_i;
          if (mem_rvalid_i && lsu_rready_i) state_nxt = IDLE;
        end
      end

      WR_LSU: begin
        // A pending LSU read stays parked (arready 0) until its own grant.
        mem_awaddr_o  = lsu_awaddr_i;
        mem_wdata_o   = lsu_wdata_i;
        mem_wstrb_o   = lsu_wstrb_i;
        mem_awvalid_o = lsu_awvalid_i & ~aw_done;
        lsu_awready_o = mem_awready_i & ~aw_done;
        mem_wvalid_o  = lsu_wvalid_i & ~w_done;
        lsu_wready_o  = mem_wready_i & ~w_done;
        if (aw_done && w_done) begin
          lsu_bvalid_o = mem_bvalid_i;
          mem_bready_o = lsu_bready_i;
          if (mem_bvalid_i && lsu_bready_i) state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of per-cycle vectors for reads and
// round-robin arbitration, then hand-written multi-cycle sequences for writes,
// AW+AR collisions, read back-pressure and reset mid-transaction.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  localparam logic [ADDR_W-1:0] IFU_ADDR = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] LSU_RADR = 32'h8000_2000;
  localparam logic [ADDR_W-1:0] LSU_WADR = 32'h8000_1000;
  localparam logic [DATA_W-1:0] LSU_WDAT = 64'h0000_0000_DEAD_BEEF;
  localparam logic [STRB_W-1:0] LSU_STRB = 8'h0F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic              ifu_arvalid = 0, ifu_arready, ifu_rvalid, ifu_rready = 0;
  logic [ADDR_W-1:0] ifu_araddr = IFU_ADDR;
  logic [DATA_W-1:0] ifu_rdata;
  logic              lsu_arvalid = 0, lsu_arready, lsu_rvalid, lsu_rready = 0;
  logic [ADDR_W-1:0] lsu_araddr = LSU_RADR;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_awvalid = 0, lsu_awready, lsu_wvalid = 0, lsu_wready;
  logic [ADDR_W-1:0] lsu_awaddr = LSU_WADR;
  logic [DATA_W-1:0] lsu_wdata = LSU_WDAT;
  logic [STRB_W-1:0] lsu_wstrb = LSU_STRB;
  logic              lsu_bvalid, lsu_bready = 0;
  logic              mem_arvalid, mem_arready = 0, mem_rvalid = 0, mem_rready;
  logic [ADDR_W-1:0] mem_araddr, mem_awaddr;
  logic [DATA_W-1:0] mem_rdata = '0, mem_wdata;
  logic              mem_awvalid, mem_awready = 0, mem_wvalid, mem_wready = 0;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_bvalid = 0, mem_bready;
  logic [1:0]        grant;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(ifu_arready), .ifu_araddr_i(ifu_araddr),
    .ifu_rvalid_o(ifu_rvalid), .ifu_rready_i(ifu_rready), .ifu_rdata_o(ifu_rdata),
    .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(lsu_arready), .lsu_araddr_i(lsu_araddr),
    .lsu_rvalid_o(lsu_rvalid), .lsu_rready_i(lsu_rready), .lsu_rdata_o(lsu_rdata),
    .lsu_awvalid_i(lsu_awvalid), .lsu_awready_o(lsu_awready), .lsu_awaddr_i(lsu_awaddr),
    .lsu_wvalid_i(lsu_wvalid), .lsu_wready_o(lsu_wready), .lsu_wdata_i(lsu_wdata),
    .lsu_wstrb_i(lsu_wstrb), .lsu_bvalid_o(lsu_bvalid), .lsu_bready_i(lsu_bready),
    .mem_arvalid_o(mem_arvalid), .mem_arready_i(mem_arready), .mem_araddr_o(mem_araddr),
    .mem_rvalid_i(mem_rvalid), .mem_rready_o(mem_rready), .mem_rdata_i(mem_rdata),
    .mem_awvalid_o(mem_awvalid), .mem_awready_i(mem_awready), .mem_awaddr_o(mem_awaddr),
    .mem_wvalid_o(mem_wvalid), .mem_wready_i(mem_wready), .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb), .mem_bvalid_i(mem_bvalid), .mem_bready_o(mem_bready),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  // Input vector, MSB first:
  //   rst | ifu_arvalid ifu_rready | lsu_arvalid lsu_rready |
  //   lsu_awvalid lsu_wvalid lsu_bready | mem_arready mem_rvalid |
  //   mem_awready mem_wready mem_bvalid
  // Handshake output vector, MSB first:
  //   mem_arvalid ifu_arready lsu_arready | mem_rready ifu_rvalid lsu_rvalid |
  //   mem_awvalid lsu_awready | mem_wvalid lsu_wready | lsu_bvalid mem_bready
  typedef struct {
    string       name;
    logic [12:0] in;
    logic [63:0] rdata;
    logic [1:0]  grant;
    logic [11:0] hs;
    logic [31:0] araddr;
    logic [63:0] ifu_rdata;
    logic [63:0] lsu_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] hs_now();
    return {mem_arvalid, ifu_arready, lsu_arready,
            mem_rready, ifu_rvalid, lsu_rvalid,
            mem_awvalid, lsu_awready,
            mem_wvalid, lsu_wready,
            lsu_bvalid, mem_bready};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then let them settle.
  task automatic drive(input logic [12:0] v, input logic [63:0] rd);
    @(negedge clk);
    {rst, ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready,
     lsu_awvalid, lsu_wvalid, lsu_bready, mem_arready, mem_rvalid,
     mem_awready, mem_wready, mem_bvalid} = v;
    mem_rdata = rd;
    #1;
  endtask

  task automatic expect_hs(input string name, input logic [1:0] g, input logic [11:0] hs);
    check({name, ".grant"}, {62'd0, grant}, {62'd0, g});
    check({name, ".hs"},    {52'd0, hs_now()}, {52'd0, hs});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // name, in, mem_rdata, grant, hs, mem_araddr, ifu_rdata, lsu_rdata
    vecs.push_back('{"reset",       13'b1_00_00_000_00_000, 64'h0,      2'b00, 12'b000_000_00_00_00, 32'h0,    64'h0,      64'h0});
    vecs.push_back('{"ifu_req",     13'b0_11_00_000_00_000, 64'h0,      2'b00, 12'b000_000_00_00_00, 32'h0,    64'h0,      64'h0});
    vecs.push_back('{"ifu_ar_stall",13'b0_11_00_000_00_000, 64'h0,      2'b01, 12'b100_000_00_00_00, IFU_ADDR, 64'h0,      64'h0});
    vecs.push_back('{"ifu_ar_hs",   13'b0_11_00_000_10_000, 64'h0,      2'b01, 12'b110_000_00_00_00, IFU_ADDR, 64'h0,      64'h0});
    vecs.push_back('{"ifu_r_wait",  13'b0_01_00_000_10_000, 64'hFFFF,   2'b01, 12'b000_100_00_00_00, IFU_ADDR, 64'h0,      64'h0});
    vecs.push_back('{"ifu_r_hs",    13'b0_01_00_000_11_000, 64'h410113, 2'b01, 12'b000_110_00_00_00, IFU_ADDR, 64'h410113, 64'h0});
    vecs.push_back('{"idle_after",  13'b0_00_00_000_00_000, 64'h0,      2'b00, 12'b000_000_00_00_00, 32'h0,    64'h0,      64'h0});
    vecs.push_back('{"both_req",    13'b0_11_11_000_00_000, 64'h0,      2'b00, 12'b000_000_00_00_00, 32'h0,    64'h0,      64'h0});
    vecs.push_back('{"lsu_first",   13'b0_11_11_000_10_000, 64'h0,      2'b10, 12'b101_000_00_00_00, LSU_RADR, 64'h0,      64'h0});
    vecs.push_back('{"lsu_r",       13'b0_11_01_000_01_000, 64'h1111_2222_3333_4444, 2'b10, 12'b000_101_00_00_00, LSU_RADR, 64'h0, 64'h1111_2222_3333_4444});
    vecs.push_back('{"ifu_waits",   13'b0_11_00_000_00_000, 64'h0,      2'b00, 12'b000_000_00_00_00, 32'h0,    64'h0,      64'h0});
    vecs.push_back('{"ifu_second",  13'b0_11_00_000_10_000, 64'h0,      2'b01, 12'b110_000_00_00_00, IFU_ADDR, 64'h0,      64'h0});
    vecs.push_back('{"ifu_r2",      13'b0_01_00_000_01_000, 64'h5555,   2'b01, 12'b000_110_00_00_00, IFU_ADDR, 64'h5555,   64'h0});
    vecs.push_back('{"both_again",  13'b0_11_11_000_00_000, 64'h0,      2'b00, 12'b000_000_00_00_00, 32'h0,    64'h0,      64'h0});
    vecs.push_back('{"lsu_again",   13'b0_11_11_000_10_000, 64'h0,      2'b10, 12'b101_000_00_00_00, LSU_RADR, 64'h0,      64'h0});
    vecs.push_back('{"lsu_r2",      13'b0_11_01_000_01_000, 64'hAAAA,   2'b10, 12'b000_101_00_00_00, LSU_RADR, 64'h0,      64'hAAAA});
    vecs.push_back('{"idle3",       13'b0_11_00_000_00_000, 64'h0,      2'b00, 12'b000_000_00_00_00, 32'h0,    64'h0,      64'h0});
    vecs.push_back('{"ifu_again",   13'b0_11_00_000_00_000, 64'h0,      2'b01, 12'b100_000_00_00_00, IFU_ADDR, 64'h0,      64'h0});

    // Two reset cycles so the state is known before the first vector.
    drive(13'b1_00_00_000_00_000, 64'h0);
    drive(13'b1_00_00_000_00_000, 64'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].in, vecs[i].rdata);
      expect_hs(vecs[i].name, vecs[i].grant, vecs[i].hs);
      check({vecs[i].name, ".araddr"},    {32'd0, mem_araddr}, {32'd0, vecs[i].araddr});
      check({vecs[i].name, ".ifu_rdata"}, ifu_rdata, vecs[i].ifu_rdata);
      check({vecs[i].name, ".lsu_rdata"}, lsu_rdata, vecs[i].lsu_rdata);
    end

    // Write with wready two cycles ahead of awready; B held off until both.
    drive(13'b1_00_00_000_00_000, 64'h0);
    drive(13'b0_00_00_111_00_000, 64'h0);
    expect_hs("wr_idle", 2'b00, 12'b000_000_00_00_00);
    drive(13'b0_00_00_111_00_010, 64'h0);
    expect_hs("wr_w_hs", 2'b11, 12'b000_000_10_11_00);
    check("wr_awaddr", {32'd0, mem_awaddr}, {32'd0, LSU_WADR});
    check("wr_wdata",  mem_wdata, LSU_WDAT);
    check("wr_wstrb",  {56'd0, mem_wstrb}, {56'd0, LSU_STRB});
    drive(13'b0_00_00_111_00_001, 64'h0);
    expect_hs("wr_aw_wait", 2'b11, 12'b000_000_10_00_00);
    drive(13'b0_00_00_111_00_101, 64'h0);
    expect_hs("wr_aw_hs", 2'b11, 12'b000_000_11_00_00);
    drive(13'b0_00_00_001_00_001, 64'h0);
    expect_hs("wr_b_hs", 2'b11, 12'b000_000_00_00_11);
    drive(13'b0_00_00_000_00_000, 64'h0);
    expect_hs("wr_done", 2'b00, 12'b000_000_00_00_00);
    check("idle_awaddr", {32'd0, mem_awaddr}, 64'd0);

    // AW and AR together: write first, read parked until its own grant.
    drive(13'b0_00_11_111_10_110, 64'h0);
    expect_hs("awar_idle", 2'b00, 12'b000_000_00_00_00);
    drive(13'b0_00_11_111_10_110, 64'h0);
    expect_hs("awar_write", 2'b11, 12'b000_000_11_11_00);
    drive(13'b0_00_11_001_10_001, 64'h0);
    expect_hs("awar_b", 2'b11, 12'b000_000_00_00_11);
    drive(13'b0_00_11_000_10_000, 64'h0);
    expect_hs("awar_gap", 2'b00, 12'b000_000_00_00_00);
    drive(13'b0_00_11_000_10_000, 64'h0);
    expect_hs("awar_read", 2'b10, 12'b101_000_00_00_00);
    check("awar_araddr", {32'd0, mem_araddr}, {32'd0, LSU_RADR});
    drive(13'b0_00_01_000_01_000, 64'h77);
    expect_hs("awar_r", 2'b10, 12'b000_101_00_00_00);
    check("awar_rdata", lsu_rdata, 64'h77);

    // IFU back-pressure: rready low for 5 cycles with rvalid high.
    drive(13'b0_10_00_000_10_000, 64'h0);
    expect_hs("bp_idle", 2'b00, 12'b000_000_00_00_00);
    drive(13'b0_10_00_000_10_000, 64'h0);
    expect_hs("bp_ar", 2'b01, 12'b110_000_00_00_00);
    for (int k = 0; k < 5; k++) begin
      drive(13'b0_00_00_000_01_000, 64'h99);
      expect_hs($sformatf("bp_stall%0d", k), 2'b01, 12'b000_010_00_00_00);
      check($sformatf("bp_rdata%0d", k), ifu_rdata, 64'h99);
    end
    drive(13'b0_01_00_000_01_000, 64'h99);
    expect_hs("bp_release", 2'b01, 12'b000_110_00_00_00);
    drive(13'b0_00_00_000_00_000, 64'h0);
    expect_hs("bp_done", 2'b00, 12'b000_000_00_00_00);

    // Reset in WR_LSU after the AW handshake, then a fresh IFU read.
    drive(13'b0_00_00_110_00_100, 64'h0);
    expect_hs("rst_idle", 2'b00, 12'b000_000_00_00_00);
    drive(13'b0_00_00_110_00_100, 64'h0);
    expect_hs("rst_aw_hs", 2'b11, 12'b000_000_11_10_00);
    drive(13'b1_00_00_110_00_100, 64'h0);
    expect_hs("rst_cycle", 2'b11, 12'b000_000_00_10_00);
    drive(13'b0_10_00_000_00_111, 64'h0);
    expect_hs("rst_after", 2'b00, 12'b000_000_00_00_00);
    check("rst_wdata", mem_wdata, 64'd0);
    drive(13'b0_10_00_000_10_000, 64'h0);
    expect_hs("rst_ifu_ar", 2'b01, 12'b110_000_00_00_00);
    drive(13'b0_01_00_000_01_000, 64'h410113);
    expect_hs("rst_ifu_r", 2'b01, 12'b000_110_00_00_00);
    check("rst_ifu_rdata", ifu_rdata, 64'h410113);
    drive(13'b0_00_00_000_00_000, 64'h0);
    expect_hs("rst_ifu_done", 2'b00, 12'b000_000_00_00_00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
